// File: rtl/lsu_ctrl.sv
// Load/store sequencer: takes one core access at a time, drives a word-wide
// req/ack data bus, and returns formatted load data or an error pulse.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        is_store,
  input  logic [1:0]  Store,
  input  logic [2:0]  Load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        access_err,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] cnt;
  logic            last_cnt;
  logic            st_q;
  logic [2:0]      code_q;
  logic [1:0]      off_q;
  logic [31:0]     addr_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            to_q;
  logic            acc_bad;
  logic [3:0]      be_nxt;
  logic [31:0]     wd_nxt;

  // Select the addressed byte/halfword and extend it according to the load code.
  function automatic logic [31:0] fmt_load(input logic [2:0]  code,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (code)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b011:  r = {24'b0, b};
      3'b100:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign last_cnt = (cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign stall    = mem_valid & ~done;

  // Decode the incoming request: legality, byte enables and replicated store data.
  always_comb begin
    acc_bad = 1'b0;
    be_nxt  = 4'b1111;
    wd_nxt  = '0;
    if (is_store) begin
      case (Store)
        2'b00: begin
          acc_bad = |addr[1:0];
          wd_nxt  = wdata;
        end
        2'b01: begin
          acc_bad = addr[0];
          be_nxt  = 4'b0011 << addr[1:0];
          wd_nxt  = {2{wdata[15:0]}};
        end
        2'b10: begin
          be_nxt  = 4'b0001 << addr[1:0];
          wd_nxt  = {4{wdata[7:0]}};
        end
        default: acc_bad = 1'b1;
      endcase
    end else begin
      case (Load)
        3'b000, 3'b011: acc_bad = 1'b0;
        3'b001, 3'b100: acc_bad = addr[0];
        3'b010:         acc_bad = |addr[1:0];
        default:        acc_bad = 1'b1;
      endcase
    end
  end

  // State register; an async reset abandons any in-flight bus access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an ack in the last allowed cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_valid) state_nxt = acc_bad ? ERR : BUS;
      BUS: begin
        if (bus_ack)       state_nxt = RESP;
        else if (last_cnt) state_nxt = ERR;
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: bus signals only carry the latched access while in BUS.
  always_comb begin
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_be      = '0;
    bus_wdata   = '0;
    done        = 1'b0;
    access_err  = 1'b0;
    timeout_err = 1'b0;
    case (state)
      BUS: begin
        bus_req   = 1'b1;
        bus_we    = st_q;
        bus_addr  = addr_q;
        bus_be    = be_q;
        bus_wdata = wdata_q;
      end
      RESP: done = 1'b1;
      ERR: begin
        done        = 1'b1;
        access_err  = ~to_q;
        timeout_err = to_q;
      end
      default: done = 1'b0;
    endcase
  end

  // Access latches, timeout counter and load-result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      st_q      <= 1'b0;
      code_q    <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      to_q      <= 1'b0;
      rdata_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            st_q    <= is_store;
            code_q  <= is_store ? {1'b0, Store} : Load;
            off_q   <= addr[1:0];
            addr_q  <= {addr[31:2], 2'b00};
            be_q    <= be_nxt;
            wdata_q <= is_store ? wd_nxt : 32'b0;
            cnt     <= '0;
            to_q    <= 1'b0;
          end
        end
        BUS: begin
          cnt <= cnt + TO_W'(1);
          if (bus_ack) begin
            if (!st_q) rdata_out <= fmt_load(code_q, off_q, bus_rdata);
          end else if (last_cnt) begin
            to_q <= 1'b1;
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed table, corner sequences, random accesses.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  Store = '0;
  logic [2:0]  Load = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall, done, access_err, timeout_err;
  logic [31:0] rdata_out;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int     n_total = 0;
  int     n_pass  = 0;
  longint cyc     = 0;
  logic [31:0] exp_rout = '0;

  lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .is_store(is_store),
    .Store(Store), .Load(Load), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata_out(rdata_out),
    .access_err(access_err), .timeout_err(timeout_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          eacc;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    logic [31:0] addr;
    bit          ld_ok;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    bit          st;
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          req_cycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    bit          stable;
    bit          done_seen;
    int          done_idx;
    longint      done_cyc;
    logic        acc;
    logic        to;
    logic [31:0] rout;
    bit          stall_ok;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic vec_t mk(input bit st, input logic [2:0] code, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int dly,
                              input bit eacc, input logic [3:0] be, input logic [31:0] ewd,
                              input bit ld_ok, input logic [31:0] erd);
    vec_t v;
    v.st = st; v.code = code; v.a = a; v.wd = wd; v.rd = rd; v.dly = dly;
    v.e.eacc = eacc; v.e.be = be; v.e.we = st; v.e.wd = ewd;
    v.e.addr = {a[31:2], 2'b00}; v.e.ld_ok = ld_ok; v.e.rd = erd;
    return v;
  endfunction

  // Reference model: what a single access should produce, from the access rules alone.
  function automatic exp_t model(input bit st, input logic [2:0] code, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    int   off;
    int   v;
    e = '{default: 0};
    off = int'(a % 4);
    e.addr = a - 32'(off);
    if (st) begin
      e.we = 1'b1;
      case (code[1:0])
        2'd0: begin e.eacc = (off != 0); e.be = 4'hF; e.wd = wd; end
        2'd1: begin e.eacc = (off % 2 != 0); e.be = 4'(3 * (1 << off)); e.wd = (wd & 32'hFFFF) * 32'h0001_0001; end
        2'd2: begin e.be = 4'(1 << off); e.wd = (wd & 32'hFF) * 32'h0101_0101; end
        default: e.eacc = 1'b1;
      endcase
    end else begin
      e.be = 4'hF;
      case (code)
        3'd0, 3'd3: begin
          v = int'((rd >> (8 * off)) & 32'hFF);
          if (code == 3'd0 && v >= 128) v -= 256;
          e.rd = 32'(v);
        end
        3'd1, 3'd4: begin
          e.eacc = (off % 2 != 0);
          v = int'((rd >> (16 * (off / 2))) & 32'hFFFF);
          if (code == 3'd1 && v >= 32768) v -= 65536;
          e.rd = 32'(v);
        end
        3'd2: begin e.eacc = (off != 0); e.rd = rd; end
        default: e.eacc = 1'b1;
      endcase
      e.ld_ok = !e.eacc;
    end
    return e;
  endfunction

  // Drive one access and act as the bus; ack arrives in bus_req cycle dly+1 (dly<0: never).
  task automatic run_access(input bit st, input logic [2:0] code, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int dly,
                            output obs_t o);
    int idx;
    o = '{default: 0};
    o.stable = 1'b1;
    o.stall_ok = 1'b1;
    is_store = st; Store = code[1:0]; Load = code; addr = a; wdata = wd;
    mem_valid = 1'b1; bus_ack = 1'b0;
    idx = 0;
    while (!o.done_seen && idx < 40) begin
      @(negedge clk);
      idx++;
      bus_ack = 1'b0;
      bus_rdata = $urandom();
      if (done) begin
        o.done_seen = 1'b1; o.done_idx = idx; o.done_cyc = cyc;
        o.acc = access_err; o.to = timeout_err; o.rout = rdata_out;
        if (stall !== 1'b0 || bus_req !== 1'b0) o.stall_ok = 1'b0;
      end else begin
        if (stall !== 1'b1) o.stall_ok = 1'b0;
        if (bus_req) begin
          o.req_cycles++;
          if (o.req_cycles == 1) begin
            o.addr = bus_addr; o.be = bus_be; o.we = bus_we; o.wd = bus_wdata;
          end else if (bus_addr !== o.addr || bus_be !== o.be || bus_we !== o.we || bus_wdata !== o.wd) begin
            o.stable = 1'b0;
          end
          if (o.req_cycles == dly + 1) begin
            bus_ack = 1'b1;
            bus_rdata = rd;
          end
        end
      end
    end
    mem_valid = 1'b0;
    bus_ack = 1'b0;
  endtask

  task automatic check_result(input string nm, input exp_t e, input int dly, input int extra, input obs_t o);
    bit is_to;
    int exp_req;
    int exp_idx;
    is_to   = !e.eacc && (dly < 0 || dly > 15);
    exp_req = e.eacc ? 0 : (is_to ? 16 : dly + 1);
    exp_idx = extra + (e.eacc ? 1 : (is_to ? 17 : dly + 2));
    chk({nm, ".done"},   32'(o.done_seen), 32'd1);
    chk({nm, ".acc"},    32'(o.acc), 32'(e.eacc));
    chk({nm, ".to"},     32'(o.to), 32'(is_to));
    chk({nm, ".reqcyc"}, 32'(o.req_cycles), 32'(exp_req));
    chk({nm, ".lat"},    32'(o.done_idx), 32'(exp_idx));
    chk({nm, ".stall"},  32'(o.stall_ok), 32'd1);
    if (!e.eacc) begin
      chk({nm, ".addr"},   o.addr, e.addr);
      chk({nm, ".be"},     32'(o.be), 32'(e.be));
      chk({nm, ".we"},     32'(o.we), 32'(e.we));
      chk({nm, ".stable"}, 32'(o.stable), 32'd1);
      if (e.we) chk({nm, ".wdata"}, o.wd, e.wd);
    end
    if (e.ld_ok && !is_to) exp_rout = e.rd;
    chk({nm, ".rdata"}, o.rout, exp_rout);
  endtask

  initial begin
    vec_t tv[$];
    obs_t o;
    obs_t o2;
    exp_t e;

    tv.push_back(mk(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 2, 0, 4'hF, 0, 1, 32'hDEADBEEF));
    tv.push_back(mk(0, 3'd0, 32'h103, 0, 32'h80FF1234, 1, 0, 4'hF, 0, 1, 32'hFFFFFF80));
    tv.push_back(mk(0, 3'd3, 32'h103, 0, 32'h80FF1234, 0, 0, 4'hF, 0, 1, 32'h00000080));
    tv.push_back(mk(0, 3'd4, 32'h102, 0, 32'h80FF1234, 3, 0, 4'hF, 0, 1, 32'h000080FF));
    tv.push_back(mk(0, 3'd1, 32'h102, 0, 32'h80FF1234, 0, 0, 4'hF, 0, 1, 32'hFFFF80FF));
    tv.push_back(mk(1, 3'd2, 32'h202, 32'h000000A5, 0, 1, 0, 4'b0100, 32'hA5A5A5A5, 0, 0));
    tv.push_back(mk(1, 3'd1, 32'h202, 32'h00001234, 0, 0, 0, 4'b1100, 32'h12341234, 0, 0));
    tv.push_back(mk(1, 3'd0, 32'h204, 32'hCAFEF00D, 0, 2, 0, 4'hF, 32'hCAFEF00D, 0, 0));
    tv.push_back(mk(0, 3'd1, 32'h101, 0, 0, 0, 1, 4'hF, 0, 0, 0));
    tv.push_back(mk(1, 3'd3, 32'h200, 32'h11, 0, 0, 1, 4'hF, 0, 0, 0));
    tv.push_back(mk(0, 3'd5, 32'h100, 0, 0, 0, 1, 4'hF, 0, 0, 0));
    tv.push_back(mk(1, 3'd0, 32'h206, 32'h22, 0, 0, 1, 4'hF, 0, 0, 0));
    tv.push_back(mk(0, 3'd2, 32'h108, 0, 32'h55555555, -1, 0, 4'hF, 0, 1, 32'h55555555));
    tv.push_back(mk(0, 3'd2, 32'h10C, 0, 32'h12345678, 15, 0, 4'hF, 0, 1, 32'h12345678));
    tv.push_back(mk(0, 3'd3, 32'h101, 0, 32'h0000AB00, 0, 0, 4'hF, 0, 1, 32'h000000AB));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.req",   32'(bus_req), 0);
    chk("rst.done",  32'(done), 0);
    chk("rst.errs",  32'({access_err, timeout_err}), 0);
    chk("rst.addr",  bus_addr, 0);
    chk("rst.be",    32'(bus_be), 0);
    chk("rst.rdata", rdata_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.req", 32'(bus_req), 0);

    // Directed table
    foreach (tv[i]) begin
      run_access(tv[i].st, tv[i].code, tv[i].a, tv[i].wd, tv[i].rd, tv[i].dly, o);
      check_result($sformatf("vec%0d", i), tv[i].e, tv[i].dly, 0, o);
      @(negedge clk);
      chk($sformatf("vec%0d.pulse", i), 32'(done), 0);
    end

    // bus_ack outside BUS must be ignored
    bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("stray_ack.done", 32'(done), 0);
    @(negedge clk);
    chk("stray_ack.rdata", rdata_out, exp_rout);

    // Reset in the middle of a bus access
    is_store = 1'b0; Load = 3'd2; Store = 2'd0; addr = 32'h400; mem_valid = 1'b1; bus_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("midbus.req_before", 32'(bus_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midbus.req",   32'(bus_req), 0);
    chk("midbus.we",    32'(bus_we), 0);
    chk("midbus.addr",  bus_addr, 0);
    chk("midbus.be",    32'(bus_be), 0);
    chk("midbus.wdata", bus_wdata, 0);
    chk("midbus.flags", 32'({done, access_err, timeout_err}), 0);
    chk("midbus.rdata", rdata_out, 0);
    exp_rout = '0;
    mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.req", 32'(bus_req), 0);

    // Back-to-back lw then sw with zero-wait acks
    run_access(0, 3'd2, 32'h300, 0, 32'h11223344, 0, o);
    check_result("b2b.lw", model(0, 3'd2, 32'h300, 0, 32'h11223344), 0, 0, o);
    run_access(1, 3'd0, 32'h304, 32'h55667788, 0, 0, o2);
    check_result("b2b.sw", model(1, 3'd0, 32'h304, 32'h55667788, 0), 0, 1, o2);
    chk("b2b.gap", 32'(o2.done_cyc - o.done_cyc), 3);
    @(negedge clk);

    // Randomized accesses against the reference model
    for (int i = 0; i < 80; i++) begin
      bit          st;
      logic [2:0]  code;
      logic [31:0] a, wd, rd;
      int          dly;
      st   = 1'($urandom_range(0, 1));
      code = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a    = 32'h1000 + 32'($urandom_range(0, 255));
      wd   = $urandom();
      rd   = $urandom();
      dly  = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      e = model(st, code, a, wd, rd);
      run_access(st, code, a, wd, rd, dly, o);
      check_result($sformatf("rnd%0d", i), e, dly, 0, o);
      @(negedge clk);
      chk($sformatf("rnd%0d.pulse", i), 32'(done), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Multicycle load/store sequencer between the RISC-V core datapath and a word-wide data-memory bus with a req/ack handshake.
- Accepts one access at a time from the core, using the decoder's Store/Load codes.
- Generates aligned word addresses, byte enables and replicated write data.
- Stalls the core until the bus acknowledges, then returns sign- or zero-extended load data.
- Reports misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, max cycles bus_req stays high without bus_ack before abort (>=1)
TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
mem_valid  input  1  core requests an access; held high until done
is_store  input  1  1 = store, 0 = load
Store  input  2  00 sw, 01 sh, 10 sb, 11 illegal
Load  input  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 101-111 illegal
addr  input  32  byte address
wdata  input  32  store data (rs2)
stall  output  1  freeze PC/pipeline
done  output  1  one-cycle completion pulse
rdata_out  output  32  formatted load result
access_err  output  1  pulse with done: misaligned or illegal code
timeout_err  output  1  pulse with done: no bus_ack in time
bus_req  output  1  bus request
bus_we  output  1  write enable
bus_addr  output  32  {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  replicated write data
bus_ack  input  1  bus completion, one cycle
bus_rdata  input  32  read word, valid with bus_ack

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE;
  - bus_req, bus_we, done, access_err, timeout_err = 0;
  - bus_addr, bus_wdata, rdata_out, counter = 0;
  - bus_be = 4'b0000.
- A reset during BUS drops bus_req immediately; the in-flight access is abandoned.
- States: IDLE, BUS, RESP, ERR.
- IDLE:
  - Exits on mem_valid=1.
  - Illegal code, or misalignment (sh/lh/lhu with addr[0]=1; sw/lw with addr[1:0]!=0) -> ERR.
  - Otherwise: latch is_store, code, addr[1:0]; register bus outputs; clear counter; -> BUS.
- BUS:
  - bus_req=1; counter increments each cycle.
  - bus_ack=1 -> capture formatted load data (loads only) -> RESP.
  - counter reaches TIMEOUT_CYCLES-1 with no ack -> ERR, with timeout_err set.
  - bus_req is therefore high at most TIMEOUT_CYCLES cycles. An ack in the final cycle wins over the timeout.
- RESP: done=1, bus_req=0 -> IDLE.
- ERR: done=1 plus exactly one of access_err or timeout_err, bus_req=0 -> IDLE.
- bus_ack is ignored outside BUS.
- stall = mem_valid & ~done (combinational), so the core advances on the done cycle.
- The next request is accepted in the following IDLE cycle.
- Latency: accept cycle N, bus_req from N+1; zero-wait ack at N+1 gives done at N+2.
- Stores:
  - bus_we=1.
  - sb: bus_be = 4'b0001 << addr[1:0], bus_wdata = {4{wdata[7:0]}}.
  - sh: bus_be = 4'b0011 << addr[1:0], bus_wdata = {2{wdata[15:0]}}.
  - sw: bus_be = 4'b1111, bus_wdata = wdata.
- Loads:
  - bus_we=0, bus_be = 4'b1111.
  - Byte select: bus_rdata[8*addr[1:0]+:8]. Halfword select: bus_rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- rdata_out holds its value until the next successful load; stores and errors leave it unchanged.
- Bus outputs hold stable for the whole BUS state and are don't-care (driven 0) in other states.

Test Plan:
- lw addr 0x100, ack 2 cycles after bus_req rises, bus_rdata 0xDEADBEEF -> bus_addr 0x100, bus_be 1111, bus_we 0; rdata_out 0xDEADBEEF; single done pulse; stall high from request through the cycle before done.
- lb addr 0x103, bus_rdata 0x80FF1234 -> rdata_out 0xFFFFFF80. Repeat as lbu -> 0x00000080. lhu addr 0x102 -> 0x000080FF.
- sb addr 0x202 wdata 0x000000A5 -> bus_be 0100, bus_wdata 0xA5A5A5A5, bus_we 1. sh addr 0x202 wdata 0x00001234 -> bus_be 1100, bus_wdata 0x12341234.
- lh addr 0x101; then Store=11 with is_store=1 -> each gives done+access_err in the cycle after request; bus_req never asserts.
- lw with bus_ack tied 0, TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, then done+timeout_err. Repeat with ack in the 16th cycle -> normal done, no error.
- rst_n pulled low mid-BUS -> bus_req 0 immediately, all outputs at reset values. After release, a back-to-back lw then sw with zero-wait acks completes with done pulses 3 cycles apart.
